// File: rtl/calc2_requester.sv
// rtl/calc2_requester.sv - calc2 port initiator: tag allocation, two-cycle issue, in-order completion
module calc2_requester #(
    parameter int DW   = 32,
    parameter int TAGS = 4
) (
    input  logic          c_clk,
    input  logic          reset,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [3:0]    op_cmd,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    output logic [3:0]    req_cmd_out,
    output logic [DW-1:0] req_data_out,
    output logic [1:0]    req_tag_out,
    input  logic [1:0]    out_resp,
    input  logic [DW-1:0] out_data,
    input  logic [1:0]    out_tag,
    output logic          cpl_valid,
    input  logic          cpl_ready,
    output logic [1:0]    cpl_resp,
    output logic [DW-1:0] cpl_data,
    output logic [1:0]    cpl_tag,
    output logic          err_unexp
);

    typedef enum logic {IDLE, OP2} state_t;

    state_t          state, state_nx;
    logic [TAGS-1:0] free_map, done;
    logic [1:0]      slot_resp [TAGS];
    logic [DW-1:0]   slot_data [TAGS];
    logic [1:0]      fifo [TAGS];
    logic [2:0]      wr_ptr, rd_ptr;
    logic [DW-1:0]   op_b_q;

    logic [1:0]      alloc_tag, head;
    logic            accept, pop, capture, fifo_empty;
    logic [TAGS-1:0] alloc_mask, pop_mask, cap_mask;
    logic [3:0]      cmd_nx;
    logic [DW-1:0]   data_nx;
    logic [1:0]      tag_nx;

    // Descending scan so the lowest free tag wins
    always_comb begin
        alloc_tag = 2'd0;
        for (int i = TAGS - 1; i >= 0; i--) begin
            if (free_map[i]) alloc_tag = 2'(i);
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign head       = fifo[rd_ptr[1:0]];
    assign op_ready   = reset && (state == IDLE) && (|free_map);
    assign accept     = op_valid && op_ready;
    assign cpl_valid  = !fifo_empty && done[head];
    assign pop        = cpl_valid && cpl_ready;
    assign capture    = (out_resp != 2'd0) && !free_map[out_tag] && !done[out_tag];
    assign cpl_resp   = slot_resp[head];
    assign cpl_data   = slot_data[head];
    assign cpl_tag    = head;

    always_comb begin
        alloc_mask = '0;
        pop_mask   = '0;
        cap_mask   = '0;
        if (accept)  alloc_mask[alloc_tag] = 1'b1;
        if (pop)     pop_mask[head]        = 1'b1;
        if (capture) cap_mask[out_tag]     = 1'b1;
    end

    always_comb begin
        state_nx = state;
        cmd_nx   = 4'd0;
        data_nx  = '0;
        tag_nx   = 2'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cmd_nx   = op_cmd;
                    data_nx  = op_a;
                    tag_nx   = alloc_tag;
                    state_nx = OP2;
                end
            end
            OP2: begin
                data_nx  = op_b_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            req_cmd_out  <= 4'd0;
            req_data_out <= '0;
            req_tag_out  <= 2'd0;
            op_b_q       <= '0;
        end else begin
            state        <= state_nx;
            req_cmd_out  <= cmd_nx;
            req_data_out <= data_nx;
            req_tag_out  <= tag_nx;
            if (accept) op_b_q <= op_b;
        end
    end

    // A tag freed by a pop is merged in after allocation, so it cannot be reused this cycle
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            free_map  <= '1;
            done      <= '0;
            wr_ptr    <= 3'd0;
            rd_ptr    <= 3'd0;
            err_unexp <= 1'b0;
            for (int i = 0; i < TAGS; i++) begin
                slot_resp[i] <= 2'd0;
                slot_data[i] <= '0;
                fifo[i]      <= 2'd0;
            end
        end else begin
            free_map  <= (free_map & ~alloc_mask) | pop_mask;
            done      <= (done | cap_mask) & ~pop_mask;
            err_unexp <= (out_resp != 2'd0) && !capture;
            if (accept) begin
                fifo[wr_ptr[1:0]] <= alloc_tag;
                wr_ptr            <= wr_ptr + 3'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 3'd1;
            if (capture) begin
                slot_resp[out_tag] <= out_resp;
                slot_data[out_tag] <= out_data;
            end
        end
    end

endmodule

// File: tb/tb_calc2_requester.sv
// tb/tb_calc2_requester.sv - directed scoreboard bench for calc2_requester
module tb_calc2_requester;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0, cpl_ready = 1'b0;
    logic [3:0]  op_cmd = 4'd0;
    logic [31:0] op_a = 32'd0, op_b = 32'd0, out_data = 32'd0;
    logic [1:0]  out_resp = 2'd0, out_tag = 2'd0;
    logic        op_ready, cpl_valid, err_unexp;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out, cpl_data;
    logic [1:0]  req_tag_out, cpl_resp, cpl_tag;

    calc2_requester #(.DW(32), .TAGS(4)) dut (
        .c_clk(c_clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd), .op_a(op_a), .op_b(op_b),
        .req_cmd_out(req_cmd_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_resp(cpl_resp),
        .cpl_data(cpl_data), .cpl_tag(cpl_tag), .err_unexp(err_unexp)
    );

    always #5 c_clk = ~c_clk;

    int cyc = 0;
    always @(posedge c_clk) cyc <= cyc + 1;

    int          passed = 0, total = 0;
    logic [35:0] sb[$];
    logic [1:0]  pend_resp [4];
    logic [31:0] pend_data [4];

    task automatic chk(input string name, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    // Stand-in for the calc2 datapath; the requester only passes its results through
    function automatic logic [33:0] model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        case (cmd)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                return {(s[32] ? 2'd2 : 2'd1), s[31:0]};
            end
            4'd2:    return {((b > a) ? 2'd2 : 2'd1), a - b};
            4'd5:    return {2'd1, a << b[4:0]};
            4'd6:    return {2'd1, a >> b[4:0]};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] exp_tag, output int acc_cyc);
        int          w;
        logic [33:0] m;
        op_valid = 1'b1; op_cmd = cmd; op_a = a; op_b = b;
        acc_cyc = -1;
        w = 0;
        @(negedge c_clk);
        while (!op_ready && w < 50) begin
            @(negedge c_clk);
            w++;
        end
        if (!op_ready) begin
            chk("issue_ready_timeout", op_ready, 1);
            op_valid = 1'b0;
            return;
        end
        @(posedge c_clk); #1;
        acc_cyc  = cyc;
        op_valid = 1'b0;
        m = model(cmd, a, b);
        pend_resp[exp_tag] = m[33:32];
        pend_data[exp_tag] = m[31:0];
        sb.push_back({m, exp_tag});
        @(negedge c_clk);
        chk("op1_wires", {req_cmd_out, req_data_out, req_tag_out}, {cmd, a, exp_tag});
        @(posedge c_clk); #1;
        chk("op2_wires", {req_cmd_out, req_data_out, req_tag_out}, {4'd0, b, 2'd0});
    endtask

    task automatic respond_raw(input logic [1:0] resp, input logic [31:0] data, input logic [1:0] tag);
        out_resp = resp; out_data = data; out_tag = tag;
        @(posedge c_clk); #1;
        out_resp = 2'd0; out_data = 32'd0; out_tag = 2'd0;
    endtask

    task automatic respond(input logic [1:0] tag);
        respond_raw(pend_resp[tag], pend_data[tag], tag);
    endtask

    task automatic pop_chk(input string name);
        int          w;
        logic [35:0] e;
        w = 0;
        @(negedge c_clk);
        while (!cpl_valid && w < 50) begin
            @(negedge c_clk);
            w++;
        end
        if (!cpl_valid) begin
            chk({name, "_timeout"}, cpl_valid, 1);
            return;
        end
        if (sb.size() == 0) begin
            chk({name, "_unexpected"}, cpl_valid, 0);
            return;
        end
        e = sb.pop_front();
        chk(name, {cpl_resp, cpl_data, cpl_tag}, e);
        cpl_ready = 1'b1;
        @(posedge c_clk); #1;
        cpl_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[5];
        int dummy, p;

        // Reset: everything low even with op_valid asserted
        op_valid = 1'b1;
        #12;
        chk("reset_outputs",
            {req_cmd_out, req_data_out, req_tag_out, cpl_valid, cpl_resp, cpl_data, cpl_tag, err_unexp, op_ready},
            77'd0);
        chk("reset_free_map", dut.free_map, 4'hF);
        op_valid = 1'b0;
        @(negedge c_clk); reset = 1'b1;
        @(posedge c_clk); #1;
        chk("ready_after_reset", op_ready, 1);

        // Single add
        issue(4'd1, 32'd5, 32'd7, 2'd0, dummy);
        respond(2'd0);
        chk("cpl_latency", cpl_valid, 1);
        pop_chk("single_add");
        chk("free_map_restored", dut.free_map, 4'hF);

        // Back-to-back four, then tag exhaustion
        issue(4'd1, 32'd10,  32'd20, 2'd0, acc[0]);
        issue(4'd2, 32'd100, 32'd1,  2'd1, acc[1]);
        issue(4'd5, 32'd1,   32'd4,  2'd2, acc[2]);
        issue(4'd6, 32'd256, 32'd2,  2'd3, acc[3]);
        for (int i = 1; i < 4; i++) chk("b2b_gap", acc[i] - acc[i-1], 2);
        op_valid = 1'b1; op_cmd = 4'd2; op_a = 32'd50; op_b = 32'd8;
        @(negedge c_clk);
        chk("exhausted_not_ready", op_ready, 0);
        for (int t = 0; t < 4; t++) respond(2'(t));
        chk("exhausted_no_pop", op_ready, 0);
        pop_chk("b2b_t0");
        p = cyc;
        issue(4'd2, 32'd50, 32'd8, 2'd0, acc[4]);
        chk("reuse_next_cycle", acc[4] - p, 1);
        respond(2'd0);
        pop_chk("b2b_t1");
        pop_chk("b2b_t2");
        pop_chk("b2b_t3");
        pop_chk("b2b_t0_reuse");

        // Out-of-order return 2, 0, 1
        issue(4'd2, 32'd9, 32'd3,   2'd0, dummy);
        issue(4'd5, 32'd3, 32'd2,   2'd1, dummy);
        issue(4'd1, 32'd40, 32'd2,  2'd2, dummy);
        respond(2'd2);
        chk("ooo_head_not_done", cpl_valid, 0);
        respond(2'd0);
        pop_chk("ooo_t0");
        chk("ooo_t2_held", cpl_valid, 0);
        respond(2'd1);
        pop_chk("ooo_t1");
        pop_chk("ooo_t2");

        // Overflow passes through with resp=2
        issue(4'd1, 32'hFFFF_FFFF, 32'd1, 2'd0, dummy);
        respond(2'd0);
        pop_chk("overflow");

        // Unexpected tag
        respond_raw(2'd1, 32'h1234, 2'd3);
        chk("unexp_pulse", err_unexp, 1);
        chk("unexp_no_cpl", cpl_valid, 0);
        @(posedge c_clk); #1;
        chk("unexp_one_cycle", err_unexp, 0);
        chk("unexp_state", {dut.free_map, dut.done}, {4'hF, 4'h0});

        // Reset during OP2 with two tags outstanding
        issue(4'd1, 32'd3, 32'd4, 2'd0, dummy);
        op_valid = 1'b1; op_cmd = 4'd2; op_a = 32'd77; op_b = 32'd5;
        @(negedge c_clk);
        @(posedge c_clk); #1;
        op_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("midflight_reset_outputs",
            {req_cmd_out, req_data_out, req_tag_out, cpl_valid, cpl_resp, cpl_data, cpl_tag, err_unexp, op_ready},
            77'd0);
        sb.delete();
        @(negedge c_clk); reset = 1'b1;
        chk("midflight_free_map", dut.free_map, 4'hF);
        @(posedge c_clk); #1;
        issue(4'd2, 32'd9, 32'd4, 2'd0, dummy);
        respond_raw(2'd1, 32'hDEAD, 2'd1);
        chk("late_resp_unexp", err_unexp, 1);
        respond(2'd0);
        pop_chk("after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
